// File: rtl/ex_exec_unit.sv
// Execute stage: single-cycle ALU plus an iterative 32-step MUL/DIVU/REMU datapath.
// Results are registered into the EX/MEM fields; stall_req holds upstream stages while iterating.
module ex_exec_unit #(
  parameter int XLEN = 32,
  parameter int ITER = XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [XLEN-1:0] ex_num1,
  input  logic [XLEN-1:0] ex_num2,
  input  logic [3:0]      ex_aluOp,
  input  logic [XLEN-1:0] ex_linkAddr,
  input  logic            ex_regWriteEn,
  input  logic [4:0]      ex_regWriteAddr,
  output logic            stall_req,
  output logic            busy,
  output logic [XLEN-1:0] mem_result,
  output logic            mem_regWriteEn,
  output logic [4:0]      mem_regWriteAddr
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_NOR  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_LINK = 4'd11;
  localparam logic [3:0] OP_MUL  = 4'd12;
  localparam logic [3:0] OP_DIVU = 4'd13;
  localparam logic [3:0] OP_REMU = 4'd14;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [3:0]      op_q;
  logic            busy_q;
  logic [XLEN-1:0] memResult_q;
  logic            memEn_q;
  logic [4:0]      memAddr_q;

  logic [XLEN-1:0] mulAcc_q, mulCand_q, mulPlier_q;
  logic [XLEN-1:0] divRem_q, divQuo_q, divSor_q;

  logic [XLEN-1:0] mulAcc_d, divRem_d, divQuo_d;
  logic [XLEN:0]   divShift, divTrial;
  logic [XLEN-1:0] aluResult, multiResult;
  logic            aluWrite, isMulti;

  assign isMulti = (ex_aluOp == OP_MUL) || (ex_aluOp == OP_DIVU) || (ex_aluOp == OP_REMU);

  // Flush and reset both cancel the stall in the same cycle they are seen.
  assign stall_req = !rst && !flush &&
                     (((state_q == S_IDLE) && isMulti) || (state_q == S_BUSY));

  assign busy             = busy_q;
  assign mem_result       = memResult_q;
  assign mem_regWriteEn   = memEn_q;
  assign mem_regWriteAddr = memAddr_q;

  always_comb begin
    aluResult = '0;
    aluWrite  = ex_regWriteEn;
    case (ex_aluOp)
      OP_ADD:  aluResult = ex_num1 + ex_num2;
      OP_SUB:  aluResult = ex_num1 - ex_num2;
      OP_AND:  aluResult = ex_num1 & ex_num2;
      OP_OR:   aluResult = ex_num1 | ex_num2;
      OP_XOR:  aluResult = ex_num1 ^ ex_num2;
      OP_NOR:  aluResult = ~(ex_num1 | ex_num2);
      OP_SLT:  aluResult = {{(XLEN-1){1'b0}}, ($signed(ex_num1) < $signed(ex_num2))};
      OP_SLL:  aluResult = ex_num2 << ex_num1[4:0];
      OP_SRL:  aluResult = ex_num2 >> ex_num1[4:0];
      OP_SRA:  aluResult = $signed(ex_num2) >>> ex_num1[4:0];
      OP_LINK: aluResult = ex_linkAddr;
      default: begin
        aluResult = '0;
        aluWrite  = 1'b0;
      end
    endcase
  end

  // One shift-add multiply step and one restoring-divide step; a zero divisor
  // naturally yields an all-ones quotient and the dividend as remainder.
  always_comb begin
    mulAcc_d = mulPlier_q[0] ? (mulAcc_q + mulCand_q) : mulAcc_q;
    divShift = {divRem_q, divQuo_q[XLEN-1]};
    divTrial = divShift - {1'b0, divSor_q};
    if (!divTrial[XLEN]) begin
      divRem_d = divTrial[XLEN-1:0];
      divQuo_d = {divQuo_q[XLEN-2:0], 1'b1};
    end else begin
      divRem_d = divShift[XLEN-1:0];
      divQuo_d = {divQuo_q[XLEN-2:0], 1'b0};
    end
    case (op_q)
      OP_MUL:  multiResult = mulAcc_q;
      OP_DIVU: multiResult = divQuo_q;
      default: multiResult = divRem_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= OP_NOP;
      busy_q      <= 1'b0;
      memResult_q <= '0;
      memEn_q     <= 1'b0;
      memAddr_q   <= '0;
      mulAcc_q    <= '0;
      mulCand_q   <= '0;
      mulPlier_q  <= '0;
      divRem_q    <= '0;
      divQuo_q    <= '0;
      divSor_q    <= '0;
    end else if (flush) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      memResult_q <= '0;
      memEn_q     <= 1'b0;
      memAddr_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (isMulti) begin
            op_q       <= ex_aluOp;
            mulAcc_q   <= '0;
            mulCand_q  <= ex_num1;
            mulPlier_q <= ex_num2;
            divRem_q   <= '0;
            divQuo_q   <= ex_num1;
            divSor_q   <= ex_num2;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            memEn_q    <= 1'b0;
            state_q    <= S_BUSY;
          end else begin
            memResult_q <= aluResult;
            memEn_q     <= aluWrite;
            memAddr_q   <= ex_regWriteAddr;
          end
        end
        S_BUSY: begin
          if (op_q == OP_MUL) begin
            mulAcc_q   <= mulAcc_d;
            mulCand_q  <= mulCand_q << 1;
            mulPlier_q <= mulPlier_q >> 1;
          end else begin
            divRem_q <= divRem_d;
            divQuo_q <= divQuo_d;
          end
          cnt_q   <= cnt_q + CW'(1);
          memEn_q <= 1'b0;
          if (cnt_q == CW'(ITER - 1))
            state_q <= S_DONE;
        end
        S_DONE: begin
          memResult_q <= multiResult;
          memEn_q     <= ex_regWriteEn;
          memAddr_q   <= ex_regWriteAddr;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_exec_unit.sv
// Directed self-checking bench for ex_exec_unit: single-cycle ops, iterative ops,
// flush, and asynchronous reset in the middle of a multiply.
module tb_ex_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] ex_num1, ex_num2, ex_linkAddr;
  logic [3:0]  ex_aluOp;
  logic        ex_regWriteEn;
  logic [4:0]  ex_regWriteAddr;
  logic        stall_req, busy;
  logic [31:0] mem_result;
  logic        mem_regWriteEn;
  logic [4:0]  mem_regWriteAddr;

  int tests = 0;
  int fails = 0;

  ex_exec_unit #(.XLEN(32), .ITER(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ex_num1(ex_num1), .ex_num2(ex_num2), .ex_aluOp(ex_aluOp),
    .ex_linkAddr(ex_linkAddr), .ex_regWriteEn(ex_regWriteEn),
    .ex_regWriteAddr(ex_regWriteAddr), .stall_req(stall_req), .busy(busy),
    .mem_result(mem_result), .mem_regWriteEn(mem_regWriteEn),
    .mem_regWriteAddr(mem_regWriteAddr)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] link, input logic en, input logic [4:0] addr);
    ex_aluOp = op; ex_num1 = a; ex_num2 = b;
    ex_linkAddr = link; ex_regWriteEn = en; ex_regWriteAddr = addr;
  endtask

  task automatic test_reset;
    rst = 1'b1; flush = 1'b0;
    drive(4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0);
    #12;
    tests++;
    if (mem_result !== 32'd0 || mem_regWriteEn !== 1'b0 || mem_regWriteAddr !== 5'd0 ||
        busy !== 1'b0 || stall_req !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset: result=%h en=%b addr=%0d busy=%b stall=%b, required all 0",
               mem_result, mem_regWriteEn, mem_regWriteAddr, busy, stall_req);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_cycle;
    logic [3:0]  opT   [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd0};
    logic [31:0] aT    [12] = '{32'h7FFFFFFF, 32'd0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,
                                32'hFFFFFFFF, 32'd4, 32'd4, 32'd4, 32'd0, 32'd7};
    logic [31:0] bT    [12] = '{32'd1, 32'd1, 32'h0FF00FF0, 32'h0F0F0F0F, 32'h0FF00FF0, 32'd0,
                                32'd1, 32'd1, 32'h80000000, 32'h80000000, 32'd0, 32'd9};
    logic [31:0] expT  [12] = '{32'h80000000, 32'hFFFFFFFF, 32'h00F000F0, 32'hFFFFFFFF, 32'hF0F0F0F0,
                                32'hFFFFFFFF, 32'd1, 32'd16, 32'h08000000, 32'hF8000000,
                                32'h00400008, 32'd0};
    logic        expEn [12] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(opT[i], aT[i], bT[i], 32'h00400008, 1'b1, 5'(i + 5));
      #1;
      tests++;
      if (stall_req !== 1'b0) begin
        fails++;
        $display("[TB] FAIL single stall op%0d: stall_req=%b, required 0", opT[i], stall_req);
      end
      @(negedge clk);
      tests++;
      if (mem_result !== expT[i] || mem_regWriteEn !== expEn[i] || mem_regWriteAddr !== 5'(i + 5)) begin
        fails++;
        $display("[TB] FAIL single op%0d: result=%h en=%b addr=%0d, required %h %b %0d",
                 opT[i], mem_result, mem_regWriteEn, mem_regWriteAddr, expT[i], expEn[i], i + 5);
      end
    end
    @(negedge clk);
    drive(4'd15, 32'd3, 32'd3, 32'd0, 1'b1, 5'd2);
    @(negedge clk);
    tests++;
    if (mem_result !== 32'd0 || mem_regWriteEn !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reserved op15: result=%h en=%b, required 0 0", mem_result, mem_regWriteEn);
    end
  endtask

  task automatic test_multi_cycle;
    logic [3:0]  opT  [5] = '{4'd12, 4'd13, 4'd14, 4'd13, 4'd14};
    logic [31:0] aT   [5] = '{32'h00010001, 32'd100, 32'd100, 32'd5, 32'd5};
    logic [31:0] bT   [5] = '{32'h00010001, 32'd7, 32'd7, 32'd0, 32'd0};
    logic [31:0] expT [5] = '{32'h00020001, 32'd14, 32'd2, 32'hFFFFFFFF, 32'd5};
    int stalls;
    logic enBad;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(opT[i], aT[i], bT[i], 32'd0, 1'b1, 5'(i + 9));
      #1;
      stalls = 0;
      enBad = 1'b0;
      while (stall_req === 1'b1 && stalls < 100) begin
        stalls++;
        @(negedge clk);
        if (mem_regWriteEn !== 1'b0) enBad = 1'b1;
      end
      tests++;
      if (stalls != 33) begin
        fails++;
        $display("[TB] FAIL multi stall count op%0d: got %0d cycles, required 33", opT[i], stalls);
      end
      tests++;
      if (enBad) begin
        fails++;
        $display("[TB] FAIL multi bubble op%0d: mem_regWriteEn=1 during stall, required 0", opT[i]);
      end
      @(negedge clk);
      tests++;
      if (mem_result !== expT[i] || mem_regWriteEn !== 1'b1 || mem_regWriteAddr !== 5'(i + 9) ||
          busy !== 1'b0) begin
        fails++;
        $display("[TB] FAIL multi op%0d: result=%h en=%b addr=%0d busy=%b, required %h 1 %0d 0",
                 opT[i], mem_result, mem_regWriteEn, mem_regWriteAddr, busy, expT[i], i + 9);
      end
      drive(4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0);
    end
  endtask

  task automatic test_flush;
    @(negedge clk);
    drive(4'd13, 32'd100, 32'd7, 32'd0, 1'b1, 5'd3);
    repeat (10) @(negedge clk);
    tests++;
    if (busy !== 1'b1 || stall_req !== 1'b1) begin
      fails++;
      $display("[TB] FAIL flush precondition: busy=%b stall=%b, required 1 1", busy, stall_req);
    end
    flush = 1'b1;
    #1;
    tests++;
    if (stall_req !== 1'b0) begin
      fails++;
      $display("[TB] FAIL flush stall: stall_req=%b, required 0", stall_req);
    end
    @(negedge clk);
    flush = 1'b0;
    drive(4'd1, 32'd2, 32'd3, 32'd0, 1'b1, 5'd4);
    tests++;
    if (busy !== 1'b0 || mem_regWriteEn !== 1'b0 || mem_result !== 32'd0) begin
      fails++;
      $display("[TB] FAIL flush state: busy=%b en=%b result=%h, required 0 0 0",
               busy, mem_regWriteEn, mem_result);
    end
    #1;
    tests++;
    if (stall_req !== 1'b0) begin
      fails++;
      $display("[TB] FAIL flush followup stall: stall_req=%b, required 0", stall_req);
    end
    @(negedge clk);
    tests++;
    if (mem_result !== 32'd5 || mem_regWriteEn !== 1'b1 || mem_regWriteAddr !== 5'd4) begin
      fails++;
      $display("[TB] FAIL flush followup add: result=%h en=%b addr=%0d, required 5 1 4",
               mem_result, mem_regWriteEn, mem_regWriteAddr);
    end
  endtask

  task automatic test_async_reset;
    int stalls;
    @(negedge clk);
    drive(4'd12, 32'h12345, 32'h6789, 32'd0, 1'b1, 5'd7);
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (mem_result !== 32'd0 || mem_regWriteEn !== 1'b0 || mem_regWriteAddr !== 5'd0 ||
        busy !== 1'b0 || stall_req !== 1'b0) begin
      fails++;
      $display("[TB] FAIL async reset: result=%h en=%b addr=%0d busy=%b stall=%b, required all 0",
               mem_result, mem_regWriteEn, mem_regWriteAddr, busy, stall_req);
    end
    drive(4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0);
    #1;
    rst = 1'b0;
    @(negedge clk);
    drive(4'd12, 32'd3, 32'd4, 32'd0, 1'b1, 5'd8);
    #1;
    stalls = 0;
    while (stall_req === 1'b1 && stalls < 100) begin
      stalls++;
      @(negedge clk);
    end
    tests++;
    if (stalls != 33) begin
      fails++;
      $display("[TB] FAIL post-reset mul stall count: got %0d, required 33", stalls);
    end
    @(negedge clk);
    tests++;
    if (mem_result !== 32'd12 || mem_regWriteEn !== 1'b1 || mem_regWriteAddr !== 5'd8) begin
      fails++;
      $display("[TB] FAIL post-reset mul: result=%h en=%b addr=%0d, required c 1 8",
               mem_result, mem_regWriteEn, mem_regWriteAddr);
    end
    drive(4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0);
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_multi_cycle();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ex_exec_unit.md
Name: ex_exec_unit

Overview:
- Execute-stage consumer of the ID/EX pipeline register: takes ex_num1, ex_num2, ex_aluOp, ex_linkAddr, ex_regWriteEn and ex_regWriteAddr, and computes the result.
- Result goes into the EX/MEM output register.
- Single-cycle ALU ops complete in one clock.
- MUL/DIVU/REMU run an iterative 32-step datapath and raise stall_req so the ID/EX register and upstream stages hold.

Parameters:
- XLEN, 32, operand/result width; MIPS core uses 32 only.
- ITER, XLEN, iterations per multi-cycle op; iteration-counter width is clog2(ITER).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  kill the in-flight instruction (branch/exception); synchronous
- ex_num1  in  XLEN  operand A from ID/EX
- ex_num2  in  XLEN  operand B from ID/EX
- ex_aluOp  in  4  operation code
- ex_linkAddr  in  XLEN  link address for JAL/JALR
- ex_regWriteEn  in  1  instruction writes a register
- ex_regWriteAddr  in  5  destination register
- stall_req  out  1  combinational; hold ID/EX and upstream stages
- busy  out  1  registered; FSM not in IDLE
- mem_result  out  XLEN  registered result to EX/MEM
- mem_regWriteEn  out  1  registered write enable to EX/MEM
- mem_regWriteAddr  out  5  registered destination to EX/MEM

Behaviour:
- Reset (rst=1, any time, async): mem_result=0, mem_regWriteEn=0, mem_regWriteAddr=0, busy=0, FSM=IDLE, iteration counter=0, internal accumulators=0.
- aluOp encoding (single-cycle):
  - 0 NOP → result 0, write forced 0
  - 1 ADD, 2 SUB: wrap mod 2^32, no overflow trap
  - 3 AND, 4 OR, 5 XOR, 6 NOR
  - 7 SLT: signed compare, result 1/0
  - 8 SLL: num2 << num1[4:0]
  - 9 SRL: num2 >> num1[4:0], logical
  - 10 SRA: num2 >>> num1[4:0], arithmetic
  - 11 LINK: result = ex_linkAddr
  - 15 reserved: result 0, write forced 0
- aluOp encoding (multi-cycle):
  - 12 MUL: low XLEN bits of num1*num2
  - 13 DIVU: unsigned quotient num1/num2
  - 14 REMU: unsigned remainder
- Single-cycle latency: result and write enable/address appear on mem_* at the next rising edge. stall_req=0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, multi-cycle op present: stall_req=1 combinationally; latch operands and op at the edge; counter←0; go to BUSY. mem_regWriteEn←0 (bubble).
  - BUSY: stall_req=1; one shift-add (MUL) or restoring shift-subtract (DIVU/REMU) step per cycle. counter++. At counter==ITER-1, go to DONE. mem_regWriteEn←0 each cycle.
  - DONE: stall_req=0; inputs are still held by ID/EX. At the edge, mem_* capture the final result plus ex_regWriteEn/ex_regWriteAddr; go to IDLE.
  - Net effect: ITER+1 (=33) stall cycles; the result is on mem_* 34 edges after the op first appears.
- Divide by zero (num2=0): no early exit, still 33 stall cycles. DIVU result 0xFFFFFFFF; REMU result num1.
- flush=1: FSM→IDLE, counter→0, stall_req=0 in that cycle, mem_regWriteEn←0, mem_result←0. Flush overrides every state and any new op in the same cycle.
- Back-to-back multi-cycle ops: after DONE, the next op is sampled in IDLE as a fresh start. There is no zero-gap restart from DONE.
- Operands are latched at BUSY entry, so input changes during BUSY are ignored.
- Write to $0 is passed through unchanged; the register file ignores it.

Test Plan:
- Reset, then ADD 0x7FFFFFFF+1, addr 5, en 1 → after 1 edge: mem_result=0x80000000, en=1, addr=5. stall_req never asserted.
- SLT 0xFFFFFFFF,1 → 1; SRA num1=4, num2=0x80000000 → 0xF8000000; LINK with linkAddr 0x00400008 → 0x00400008.
- MUL 0x00010001×0x00010001, addr 9 → stall_req high 33 cycles; mem_regWriteEn=0 throughout; then mem_result=0x00020001, addr 9, en 1; busy back to 0.
- DIVU 100/7 → 14; REMU 100/7 → 2; DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5; each takes 33 stall cycles.
- Flush at BUSY cycle 10 of a DIVU → stall_req low that cycle; FSM IDLE; mem_regWriteEn=0. A following ADD 2+3 completes normally with result 5.
- rst pulsed asynchronously mid-MUL (between edges) → all outputs 0 immediately, busy=0. After release, MUL 3×4 runs the full 33 cycles → 12.
